// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush/bubble controller for the 5-stage core, with a redirect-drain FSM,
// saturating performance counters and a sticky stall watchdog.
//
// state | meaning
// RUN   | normal operation, priority rules select enables/flushes/bubbles
// DRAIN | redirect accepted while a fetch was in flight; discard one stale word
module pipeline_stall_controller #(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hazard_stall,
    input  logic             branch_redirect,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_sel_redirect,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_write,
    output logic             mem_wb_bubble,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             stall_timeout
);

    localparam int WD_W = $clog2(MAX_STALL + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wd_count;

    logic mem_freeze;
    logic accept_redirect;
    logic enter_drain;

    logic pcw_c, psr_c, ifw_c, ifl_c, idb_c, exw_c, mwb_c;

    assign mem_freeze = dmem_req & ~dmem_ready;

    always_comb begin
        pcw_c           = 1'b1;
        psr_c           = 1'b0;
        ifw_c           = 1'b1;
        ifl_c           = 1'b0;
        idb_c           = 1'b0;
        exw_c           = 1'b1;
        mwb_c           = 1'b0;
        accept_redirect = 1'b0;
        enter_drain     = 1'b0;
        case (state)
            RUN: begin
                if (mem_freeze) begin
                    pcw_c = 1'b0;
                    ifw_c = 1'b0;
                    exw_c = 1'b0;
                    mwb_c = 1'b1;
                end else if (hazard_stall) begin
                    pcw_c = 1'b0;
                    ifw_c = 1'b0;
                    idb_c = 1'b1;
                end else if (branch_redirect) begin
                    psr_c           = 1'b1;
                    ifl_c           = 1'b1;
                    accept_redirect = 1'b1;
                    enter_drain     = ~imem_ready;
                end else if (!imem_ready) begin
                    pcw_c = 1'b0;
                    ifl_c = 1'b1;
                end
            end
            DRAIN: begin
                // The stale word must never reach ID; a memory freeze still wins on the back end.
                pcw_c = 1'b0;
                if (mem_freeze) begin
                    ifw_c = 1'b0;
                    exw_c = 1'b0;
                    mwb_c = 1'b1;
                end else begin
                    ifl_c = 1'b1;
                end
            end
            default: begin
                pcw_c = 1'b0;
                ifl_c = 1'b1;
            end
        endcase
    end

    // Reset forces the pipeline into a safe frozen, all-NOP configuration.
    assign pc_write         = rst_n & pcw_c;
    assign pc_sel_redirect  = rst_n & psr_c;
    assign if_id_write      = rst_n & ifw_c;
    assign if_id_flush      = ~rst_n | ifl_c;
    assign id_ex_bubble     = ~rst_n | idb_c;
    assign ex_mem_write     = rst_n & exw_c;
    assign mem_wb_bubble    = ~rst_n | mwb_c;
    assign redirect_pending = (state == DRAIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (enter_drain) state <= DRAIN;
                DRAIN:   if (imem_ready)  state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pcw_c && stall_cycles != {CNT_W{1'b1}})
                stall_cycles <= stall_cycles + 1'b1;
            if (accept_redirect && flush_count != {CNT_W{1'b1}})
                flush_count <= flush_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_count      <= '0;
            stall_timeout <= 1'b0;
        end else if (pcw_c) begin
            wd_count <= '0;
        end else if (wd_count != WD_MAX) begin
            wd_count <= wd_count + 1'b1;
            if (wd_count + 1'b1 == WD_MAX)
                stall_timeout <= 1'b1;
        end
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumes the stall request from hazard detection, plus redirect and memory-handshake status, and drives every pipeline-register enable, flush and bubble control in the 5-stage core.
- Owns one registered piece of control state: a pending-redirect drain for a fetch still in flight.
- Also keeps saturating performance counters and a stall watchdog.
- Sits between the hazard unit, fetch, and the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- CNT_W, 32, width of the stall_cycles and flush_count counters.
- MAX_STALL, 64, number of consecutive cycles with pc_write=0 that sets stall_timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- hazard_stall  in  1  load-use or branch-data stall request
- branch_redirect  in  1  taken branch or jump resolved in ID this cycle
- imem_ready  in  1  fetch word valid this cycle
- dmem_req  in  1  MEM stage holds a load or store
- dmem_ready  in  1  data memory completes this cycle
- pc_write  out  1  PC update enable
- pc_sel_redirect  out  1  PC loads the redirect target
- if_id_write  out  1  IF/ID enable
- if_id_flush  out  1  IF/ID loads a NOP
- id_ex_bubble  out  1  ID/EX loads a NOP
- ex_mem_write  out  1  ID/EX and EX/MEM advance enable
- mem_wb_bubble  out  1  MEM/WB loads a NOP
- redirect_pending  out  1  FSM is in DRAIN
- stall_cycles  out  CNT_W  count of cycles with pc_write=0
- flush_count  out  CNT_W  count of accepted redirects
- stall_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset: async assert on rst_n=0.
  - State goes to RUN; counters, watchdog and stall_timeout go to 0.
  - While rst_n=0, outputs are forced: pc_write=0, if_id_write=0, ex_mem_write=0, pc_sel_redirect=0, if_id_flush=1, id_ex_bubble=1, mem_wb_bubble=1.
- Default (no condition active): pc_write=1, if_id_write=1, ex_mem_write=1, all flush/bubble/select outputs 0.
- Control outputs are combinational from state and inputs. Zero latency: a request affects the same edge's register update.
- Define mem_freeze = dmem_req & ~dmem_ready. Priority in RUN, highest first:
  1. mem_freeze: pc_write=0, if_id_write=0, ex_mem_write=0, mem_wb_bubble=1. hazard_stall and branch_redirect are ignored because ID is frozen and re-presents them.
  2. hazard_stall: pc_write=0, if_id_write=0, id_ex_bubble=1, ex_mem_write=1. branch_redirect is ignored.
  3. branch_redirect & imem_ready: pc_write=1, pc_sel_redirect=1, if_id_flush=1. Counts as an accepted redirect.
  4. branch_redirect & ~imem_ready: same outputs as rule 3, and next state is DRAIN. Counts as an accepted redirect.
  5. ~imem_ready: pc_write=0, if_id_flush=1 (bubble into ID).
- DRAIN state: one stale fetch word is outstanding.
  - Outputs: pc_write=0 and pc_sel_redirect=0. if_id_flush=1 unless mem_freeze; under mem_freeze, the rule-1 outputs apply.
  - hazard_stall and branch_redirect are ignored.
  - imem_ready=1 consumes the stale word (it is discarded) and next state is RUN. This applies regardless of mem_freeze.
  - No timeout in DRAIN.
- redirect_pending = (state == DRAIN).
- stall_cycles: +1 on every post-reset cycle with pc_write=0. Saturates at all-ones.
- flush_count: +1 per accepted redirect (rules 3 and 4 only). Saturates at all-ones.
- Watchdog:
  - Counts consecutive cycles with pc_write=0 and clears on any cycle with pc_write=1.
  - When it reaches MAX_STALL, stall_timeout is set. The counter saturates there.
  - stall_timeout stays set until reset.
- Reset asserted mid-DRAIN returns the FSM to RUN. The stale word is not tracked after reset.

Test Plan:
- Idle: rst_n=1, imem_ready=1, all other inputs 0 -> pc_write=1, if_id_write=1, ex_mem_write=1, all flush/bubble outputs 0, stall_cycles stays 0.
- Load-use: hazard_stall=1 for 1 cycle with branch_redirect=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1, pc_sel_redirect=0. flush_count stays 0 and stall_cycles=1.
- Redirect during slow fetch:
  - branch_redirect=1, imem_ready=0 -> pc_sel_redirect=1, redirect_pending=1 next cycle.
  - Hold imem_ready=0 for 3 cycles -> pc_write=0, if_id_flush=1 throughout.
  - imem_ready=1 -> redirect_pending=0 next cycle. flush_count=1.
- Memory freeze over stall: dmem_req=1, dmem_ready=0 for 4 cycles with hazard_stall=1 -> ex_mem_write=0, mem_wb_bubble=1, id_ex_bubble=0 each cycle. Then dmem_ready=1 -> the hazard_stall response applies.
- Watchdog: MAX_STALL=4, hazard_stall=1 for 5 cycles -> stall_timeout rises at the 4th stalled cycle and stays 1 after hazard_stall drops. Only rst_n=0 clears it.
- Counters and reset: CNT_W=2, 5 stall cycles -> stall_cycles=3 (saturated). Async rst_n low mid-DRAIN -> counters 0, redirect_pending=0, outputs at their reset values.
